// File: rtl/udp_pkg.sv
// Shared definitions for the UDP receive packer: FSM state encoding,
// default payload capacity and a saturating 16-bit increment helper.
package udp_pkg;

    localparam int UDP_MAX_BYTES = 120;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2,
        DROP    = 2'd3
    } udp_state_e;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/udp_rx_packer.sv
// UDP receive packer: gathers the payload bytes of one datagram into a wide
// word (first byte in the top byte lane), presents it with a valid/ready
// handshake and drops whole datagrams that arrive while a word is still held.
// Optional feature: define UDP_RX_DROP_CNT_EN to get the drop_cnt port and
// its saturating counter of dropped datagrams.
module udp_rx_packer
    import udp_pkg::*;
#(
    parameter int MAX_BYTES = UDP_MAX_BYTES,
    parameter int DATA_W    = 8 * MAX_BYTES
) (
    input  logic              clk_200m,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic [15:0]       in_length,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       out_length,
    output logic              out_trunc
`ifdef UDP_RX_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int          PW      = $clog2(DATA_W);
    localparam logic [15:0] MAX_B16 = 16'(MAX_BYTES);

    udp_state_e        state_q, state_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       len_q, len_d;
    logic              trunc_q, trunc_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       out_len_q, out_len_d;
    logic              out_trunc_q, out_trunc_d;
`ifdef UDP_RX_DROP_CNT_EN
    logic [15:0]       drop_cnt_q, drop_cnt_d;
`endif

    logic              xfer_s;
    logic              start_s;
    logic              step_s;
    logic              end_s;
    logic [15:0]       fin_count_s;
    logic              fin_trunc_s;
    logic [PW-1:0]     pos_s;

    // Bit position of the top of the byte lane addressed by the running count.
    assign pos_s = PW'(DATA_W - 1 - 8 * int'(count_q));

    // Next-state logic: FSM sequencing, byte placement and word completion.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        count_d     = count_q;
        len_d       = len_q;
        trunc_d     = trunc_q;
        out_valid_d = out_valid_q;
        out_len_d   = out_len_q;
        out_trunc_d = out_trunc_q;
`ifdef UDP_RX_DROP_CNT_EN
        drop_cnt_d  = drop_cnt_q;
`endif
        xfer_s      = out_valid_q & out_ready;
        start_s     = 1'b0;
        step_s      = 1'b0;
        end_s       = 1'b0;
        fin_count_s = count_q;
        fin_trunc_s = trunc_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    start_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    step_s = 1'b1;
                end else begin
                    end_s = 1'b1;
                end
            end
            HOLD: begin
                if (xfer_s) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        // Back-to-back: the new datagram starts in the transfer cycle.
                        start_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (in_valid) begin
                    state_d = DROP;
`ifdef UDP_RX_DROP_CNT_EN
                    drop_cnt_d = sat_inc16(drop_cnt_q);
`endif
                end else begin
                    state_d = HOLD;
                end
            end
            DROP: begin
                if (xfer_s) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
                if (!in_valid) begin
                    state_d = (xfer_s || !out_valid_q) ? IDLE : HOLD;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_s) begin
            buf_d                = '0;
            buf_d[DATA_W-1 -: 8] = in_data;
            count_d              = 16'd1;
            trunc_d              = 1'b0;
            len_d                = (in_length == 16'd0) ? 16'd1 : in_length;
            fin_count_s          = 16'd1;
            fin_trunc_s          = 1'b0;
            if (in_length <= 16'd1) begin
                end_s = 1'b1;
            end else begin
                state_d = COLLECT;
            end
        end else if (step_s) begin
            if (count_q < MAX_B16) begin
                buf_d[pos_s -: 8] = in_data;
            end else begin
                trunc_d = 1'b1;
            end
            count_d     = sat_inc16(count_q);
            fin_count_s = count_d;
            fin_trunc_s = trunc_d;
            if (count_d >= len_q) begin
                end_s = 1'b1;
            end else begin
                state_d = COLLECT;
            end
        end else begin
            fin_count_s = count_q;
        end

        if (end_s) begin
            out_valid_d = 1'b1;
            out_len_d   = (fin_count_s > MAX_B16) ? MAX_B16 : fin_count_s;
            out_trunc_d = fin_trunc_s;
            state_d     = HOLD;
        end else begin
            out_len_d = out_len_d;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_200m) begin
        if (!rstn) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            count_q     <= 16'd0;
            len_q       <= 16'd0;
            trunc_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_len_q   <= 16'd0;
            out_trunc_q <= 1'b0;
`ifdef UDP_RX_DROP_CNT_EN
            drop_cnt_q  <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            count_q     <= count_d;
            len_q       <= len_d;
            trunc_q     <= trunc_d;
            out_valid_q <= out_valid_d;
            out_len_q   <= out_len_d;
            out_trunc_q <= out_trunc_d;
`ifdef UDP_RX_DROP_CNT_EN
            drop_cnt_q  <= drop_cnt_d;
`endif
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = buf_q;
    assign out_length = out_len_q;
    assign out_trunc  = out_trunc_q;
`ifdef UDP_RX_DROP_CNT_EN
    assign drop_cnt   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_udp_rx_packer.sv
// Scoreboard bench for udp_rx_packer: directed datagrams push their expected
// word into a queue; a negedge monitor pops and compares on every transfer.
module tb_udp_rx_packer;

    localparam int MB = 120;
    localparam int DW = 960;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [15:0]   len;
        logic          trunc;
    } exp_t;

    logic          clk_200m = 1'b0;
    logic          rstn;
    logic          in_valid;
    logic [7:0]    in_data;
    logic [15:0]   in_length;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [15:0]   out_length;
    logic          out_trunc;
`ifdef UDP_RX_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk_200m = ~clk_200m;

    udp_rx_packer #(.MAX_BYTES(MB), .DATA_W(DW)) dut (
        .clk_200m  (clk_200m),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_length (in_length),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_length(out_length),
        .out_trunc (out_trunc)
`ifdef UDP_RX_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    function automatic logic [7:0] bval(input int kind, input int i);
        case (kind)
            0:       return 8'(17 * (i + 1));   // 11,22,33,44,55...
            1:       return 8'(i);
            2:       return 8'(160 + i);
            default: return 8'(48 + i);
        endcase
    endfunction

    function automatic exp_t model(input int n, input int kind, input int start);
        exp_t e;
        e.data = '0;
        for (int i = 0; i < n; i++) begin
            if (i < MB) e.data[DW-1-8*i -: 8] = bval(kind, start + i);
        end
        e.len   = (n > MB) ? 16'(MB) : 16'(n);
        e.trunc = (n > MB);
        return e;
    endfunction

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_w(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got top=%h low=%h expected top=%h low=%h",
                     nm, act[DW-1 -: 64], act[63:0], exp[DW-1 -: 64], exp[63:0]);
        end
    endtask

    task automatic send(input int n, input int kind, input int start, input logic rdy_first);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_200m); #1;
            in_valid = 1'b1;
            in_data  = bval(kind, start + i);
            if (i == 0 && rdy_first) out_ready = 1'b1;
        end
        @(posedge clk_200m); #1;
        in_valid = 1'b0;
    endtask

    // Monitor: any valid word must be expected; each transfer is scored.
    always @(negedge clk_200m) begin
        if (rstn && out_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got out_valid=1 expected no word (len %0d)", out_length);
            end else if (out_ready) begin
                exp_t e;
                e = exp_q.pop_front();
                check_w("sb_data", out_data, e.data);
                check64("sb_len", 64'(out_length), 64'(e.len));
                check64("sb_trunc", 64'(out_trunc), 64'(e.trunc));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_length = 16'd0;
        out_ready = 1'b0;

        // Reset: all outputs zero while rstn is low for 3 cycles.
        repeat (3) begin
            @(negedge clk_200m);
            check64("rst_valid", 64'(out_valid), 64'd0);
            check64("rst_len", 64'(out_length), 64'd0);
            check64("rst_trunc", 64'(out_trunc), 64'd0);
            check_w("rst_data", out_data, '0);
`ifdef UDP_RX_DROP_CNT_EN
            check64("rst_drop", 64'(drop_cnt), 64'd0);
`endif
        end
        @(posedge clk_200m); #1;
        rstn = 1'b1;

        // 4-byte datagram, ready held high: 1-cycle latency, 1-cycle pulse.
        out_ready = 1'b1;
        in_length = 16'd4;
        exp_q.push_back(model(4, 0, 0));
        send(4, 0, 0, 1'b0);
        @(negedge clk_200m);
        check64("t1_valid", 64'(out_valid), 64'd1);
        check64("t1_top32", 64'(out_data[DW-1 -: 32]), 64'h11223344);
        check_w("t1_rest", {32'h0, out_data[DW-33:0]}, '0);
        @(negedge clk_200m);
        check64("t1_pulse_end", 64'(out_valid), 64'd0);

        // 130-byte datagram: truncated to 120 bytes, last stored byte 119.
        in_length = 16'd130;
        exp_q.push_back(model(130, 1, 0));
        send(130, 1, 0, 1'b0);
        @(negedge clk_200m);
        check64("t2_valid", 64'(out_valid), 64'd1);
        check64("t2_last", 64'(out_data[7:0]), 64'd119);
        check64("t2_len", 64'(out_length), 64'd120);
        check64("t2_trunc", 64'(out_trunc), 64'd1);
        @(negedge clk_200m);

        // Ready low 50 cycles; second datagram is dropped, first word held.
        out_ready = 1'b0;
        in_length = 16'd8;
        exp_q.push_back(model(8, 2, 0));
        send(8, 2, 0, 1'b0);
        send(8, 3, 0, 1'b0);
        repeat (32) @(posedge clk_200m);
        @(negedge clk_200m);
        check64("t3_held_valid", 64'(out_valid), 64'd1);
        check_w("t3_held_data", out_data, model(8, 2, 0).data);
        check64("t3_held_len", 64'(out_length), 64'd8);
`ifdef UDP_RX_DROP_CNT_EN
        check64("t3_drop", 64'(drop_cnt), 64'd1);
`endif
        @(posedge clk_200m); #1;
        out_ready = 1'b1;
        @(negedge clk_200m);
        @(negedge clk_200m);
        check64("t3_after_xfer", 64'(out_valid), 64'd0);

        // Ready rises with the first byte of the next datagram: no loss.
        out_ready = 1'b0;
        in_length = 16'd4;
        exp_q.push_back(model(4, 1, 80));
        send(4, 1, 80, 1'b0);
        repeat (3) @(posedge clk_200m);
        #1;
        in_length = 16'd6;
        exp_q.push_back(model(6, 1, 96));
        send(6, 1, 96, 1'b1);
        @(negedge clk_200m);
        check64("t4_valid", 64'(out_valid), 64'd1);
`ifdef UDP_RX_DROP_CNT_EN
        check64("t4_drop", 64'(drop_cnt), 64'd1);
`endif
        @(negedge clk_200m);

        // in_length 0 behaves as a 1-byte datagram.
        in_length = 16'd0;
        exp_q.push_back(model(1, 0, 4));
        send(1, 0, 4, 1'b0);
        @(negedge clk_200m);
        check64("t5_valid", 64'(out_valid), 64'd1);
        check64("t5_top", 64'(out_data[DW-1 -: 8]), 64'h55);
        check64("t5_trunc", 64'(out_trunc), 64'd0);
        @(negedge clk_200m);

        // Reset after 3 of 10 bytes: remaining 7 bytes form a new word.
        in_length = 16'd10;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_200m); #1;
            in_valid = 1'b1;
            in_data  = bval(3, i);
        end
        @(posedge clk_200m); #1;
        in_valid = 1'b0;
        rstn     = 1'b0;
        @(posedge clk_200m); #1;
        rstn = 1'b1;
        @(negedge clk_200m);
        check64("t6_no_partial", 64'(out_valid), 64'd0);
        exp_q.push_back(model(7, 3, 3));
        send(7, 3, 3, 1'b0);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk_200m);
        repeat (3) @(negedge clk_200m);
        check64("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
